// File: rtl/discriminator_if.sv
// discriminator_if: sample-in / score-out handshake bundle for discriminator_seq
// master = sample source and score consumer; slave = discriminator
interface discriminator_if #(
    parameter int N_IN = 9,
    parameter int DW = 16
);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [N_IN*DW-1:0] in_pixels;
    logic [DW-1:0] o_score, o_logit;
    modport master (output in_valid, in_pixels, out_ready, input in_ready, out_valid, o_score, o_logit);
    modport slave (input in_valid, in_pixels, out_ready, output in_ready, out_valid, o_score, o_logit);
endinterface

// File: rtl/discriminator_seq.sv
// discriminator_seq: two-layer Q8.8 GAN discriminator time-multiplexed on one shared MAC
// Ports: clk; rst_n (synchronous, active-low); bus (slave: in_valid/in_ready/in_pixels,
// out_valid/out_ready/o_score/o_logit); flat_weights_D1/D2 hidden and output weights, sampled live
module discriminator_seq #(
    parameter int N_IN = 9,
    parameter int N_HID = 3,
    parameter int DW = 16,
    parameter int FRAC = 8,
    parameter int HID_ACT = 0
) (
    input  logic clk,
    input  logic rst_n,
    discriminator_if.slave bus,
    input  logic [N_HID*(N_IN+1)*DW-1:0] flat_weights_D1,
    input  logic [(N_HID+1)*DW-1:0] flat_weights_D2
);
    localparam int AW = 2*DW + $clog2(N_IN+1);
    localparam int CW = $clog2(N_IN + N_HID + 1);
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] ONE = DW'(1 << FRAC);
    localparam logic signed [DW-1:0] HALF = DW'(1 << (FRAC-1));
    typedef enum logic [2:0] {IDLE, L1_MAC, L1_FIN, L2_MAC, L2_FIN, DONE} state_t;
    state_t state, nxt;
    logic live, accept, last_in;
    logic [CW-1:0] idx, neuron;
    logic [N_IN*DW-1:0] pix;
    logic [N_HID*DW-1:0] hid;
    logic signed [AW-1:0] acc, sum;
    logic signed [DW-1:0] a_op, b_op, bias, sat, act, sig, score;
    logic signed [2*DW-1:0] prod;
    always_comb begin
        accept = live && state == IDLE && bus.in_valid;
        last_in = idx == CW'(N_IN-1);
        bus.in_ready = live && state == IDLE;
        bus.out_valid = state == DONE;
        // idx walks pixels in layer 1 and hidden neurons in layer 2
        a_op = state == L2_MAC ? $signed(hid[DW*idx +: DW]) : $signed(pix[DW*idx +: DW]);
        b_op = state == L2_MAC ? $signed(flat_weights_D2[DW*idx +: DW])
                               : $signed(flat_weights_D1[DW*((N_IN+1)*neuron + idx) +: DW]);
        prod = (2*DW)'(a_op) * (2*DW)'(b_op);
        bias = state == L2_FIN ? $signed(flat_weights_D2[DW*N_HID +: DW])
                               : $signed(flat_weights_D1[DW*((N_IN+1)*neuron + N_IN) +: DW]);
        sum = acc + AW'(bias);
        sat = sum > SMAX ? SMAX[DW-1:0] : sum < SMIN ? SMIN[DW-1:0] : sum[DW-1:0];
        act = HID_ACT != 0 ? (sat[DW-1] ? '0 : sat) : (sat > ONE ? ONE : sat < -ONE ? -ONE : sat);
        sig = (sat >>> 2) + HALF;
        score = sig < 0 ? '0 : sig > ONE ? ONE : sig;
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? L1_MAC : IDLE;
            L1_MAC:  nxt = last_in ? L1_FIN : L1_MAC;
            L1_FIN:  nxt = neuron == CW'(N_HID-1) ? L2_MAC : L1_MAC;
            L2_MAC:  nxt = idx == CW'(N_HID-1) ? L2_FIN : L2_MAC;
            L2_FIN:  nxt = DONE;
            default: nxt = bus.out_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live <= 1'b0;
            acc <= '0;
            hid <= '0;
            idx <= '0;
            neuron <= '0;
            pix <= '0;
            bus.o_score <= '0;
            bus.o_logit <= '0;
        end else begin
            live <= 1'b1;
            if (accept)
                pix <= bus.in_pixels;
            // outside the MAC states the accumulator is held at zero, ready for the next sum
            acc <= (state == L1_MAC || state == L2_MAC) ? acc + AW'(prod >>> FRAC) : '0;
            idx <= ((state == L1_MAC && !last_in) || state == L2_MAC) ? idx + 1'b1 : '0;
            neuron <= state == IDLE ? '0 : state == L1_FIN ? neuron + 1'b1 : neuron;
            if (state == L1_FIN)
                hid[DW*neuron +: DW] <= act;
            if (state == L2_FIN) begin
                bus.o_logit <= sat;
                bus.o_score <= score;
            end
        end
    end
endmodule

// File: tb/tb_discriminator_seq.sv
// tb_discriminator_seq: directed checks of discriminator_seq (ReLU and small builds alongside)
module tb_discriminator_seq;
    localparam int N_IN = 9, N_HID = 3, DW = 16, L = N_HID*(N_IN+1) + N_HID + 1;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N_HID*(N_IN+1)*DW-1:0] w1;
    logic [(N_HID+1)*DW-1:0] w2;
    logic [2*5*DW-1:0] w1s;
    logic [3*DW-1:0] w2s;
    int errors = 0, checks = 0, lat = 0;
    discriminator_if #(.N_IN(N_IN), .DW(DW)) ia(), ib();
    discriminator_if #(.N_IN(4), .DW(DW)) ic();
    discriminator_seq #(.HID_ACT(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave), .flat_weights_D1(w1), .flat_weights_D2(w2));
    discriminator_seq #(.HID_ACT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave), .flat_weights_D1(w1), .flat_weights_D2(w2));
    discriminator_seq #(.N_IN(4), .N_HID(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave), .flat_weights_D1(w1s), .flat_weights_D2(w2s));
    always #5 clk = ~clk;
    function automatic logic [N_IN*DW-1:0] fill(input logic [DW-1:0] v);
        return {N_IN{v}};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic v, input logic [N_IN*DW-1:0] p, input logic ordy);
        ia.in_valid = v;
        ib.in_valid = v;
        ia.in_pixels = p;
        ib.in_pixels = p;
        ia.out_ready = ordy;
        ib.out_ready = ordy;
    endtask
    task automatic set_w(input logic [DW-1:0] wv, input logic [DW-1:0] b1, input logic [DW-1:0] w2v, input logic [DW-1:0] b2);
        for (int i = 0; i < N_HID; i++)
            for (int k = 0; k <= N_IN; k++)
                w1[DW*(i*(N_IN+1)+k) +: DW] = (k == N_IN) ? b1 : wv;
        for (int j = 0; j <= N_HID; j++)
            w2[DW*j +: DW] = (j == N_HID) ? b2 : w2v;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ia.out_valid && n < 200);
    endtask
    task automatic run(input logic [N_IN*DW-1:0] p);
        drive(1'b1, p, 1'b0);
        step();
        drive(1'b0, fill(16'hDEAD), 1'b0);
        wait_done(lat);
    endtask
    task automatic ack();
        drive(1'b0, fill(16'hDEAD), 1'b1);
        step();
        drive(1'b0, fill(16'hDEAD), 1'b0);
    endtask
    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        ic.in_valid = 1'b0;
        ic.in_pixels = '0;
        ic.out_ready = 1'b0;
        set_w(16'h0080, 16'h0000, 16'h0040, 16'h0000);
        rst_n = 1'b0;
        step();
        step();
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", ia.in_ready); end
        checks++; if (ia.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ia.out_valid); end
        checks++; if (ia.o_score !== 16'h0000 || ia.o_logit !== 16'h0000) begin errors++; $display("FAIL reset_outputs got=%h/%h exp=0000/0000", ia.o_score, ia.o_logit); end
        rst_n = 1'b1;
        step();
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ia.in_ready); end
    endtask
    task automatic test_basic();
        set_w(16'h0080, 16'h0000, 16'h0040, 16'h0000);
        run(fill(16'h0100));
        checks++; if (lat != L) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, L); end
        for (int i = 0; i < N_HID; i++) begin
            checks++; if (dut_a.hid[DW*i +: DW] !== 16'h0100) begin errors++; $display("FAIL basic_hidden%0d got=%h exp=0100", i, dut_a.hid[DW*i +: DW]); end
        end
        checks++; if (ia.o_logit !== 16'h00C0) begin errors++; $display("FAIL basic_logit got=%h exp=00C0", ia.o_logit); end
        checks++; if (ia.o_score !== 16'h00B0) begin errors++; $display("FAIL basic_score got=%h exp=00B0", ia.o_score); end
        checks++; if (ib.o_logit !== 16'h0360) begin errors++; $display("FAIL relu_basic_logit got=%h exp=0360", ib.o_logit); end
        checks++; if (ib.o_score !== 16'h0100) begin errors++; $display("FAIL relu_basic_score got=%h exp=0100", ib.o_score); end
        ack();
        checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ack got=%b%b exp=01", ia.out_valid, ia.in_ready); end
    endtask
    task automatic test_negative();
        set_w(16'hFF80, 16'h0000, 16'h0040, 16'h0000);
        run(fill(16'h0100));
        for (int i = 0; i < N_HID; i++) begin
            checks++; if (dut_a.hid[DW*i +: DW] !== 16'hFF00) begin errors++; $display("FAIL neg_hidden%0d got=%h exp=FF00", i, dut_a.hid[DW*i +: DW]); end
        end
        checks++; if (ia.o_logit !== 16'hFF40) begin errors++; $display("FAIL neg_logit got=%h exp=FF40", ia.o_logit); end
        checks++; if (ia.o_score !== 16'h0050) begin errors++; $display("FAIL neg_score got=%h exp=0050", ia.o_score); end
        checks++; if (dut_b.hid !== '0) begin errors++; $display("FAIL relu_neg_hidden got=%h exp=0", dut_b.hid); end
        checks++; if (ib.o_logit !== 16'h0000) begin errors++; $display("FAIL relu_neg_logit got=%h exp=0000", ib.o_logit); end
        checks++; if (ib.o_score !== 16'h0080) begin errors++; $display("FAIL relu_neg_score got=%h exp=0080", ib.o_score); end
        ack();
    endtask
    task automatic test_saturation();
        set_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        run(fill(16'h7FFF));
        checks++; if (ia.o_logit !== 16'h7FFF) begin errors++; $display("FAIL sat_hi_logit got=%h exp=7FFF", ia.o_logit); end
        checks++; if (ia.o_score !== 16'h0100) begin errors++; $display("FAIL sat_hi_score got=%h exp=0100", ia.o_score); end
        ack();
        set_w(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
        run(fill(16'h7FFF));
        checks++; if (ia.o_logit !== 16'h8000) begin errors++; $display("FAIL sat_lo_logit got=%h exp=8000", ia.o_logit); end
        checks++; if (ia.o_score !== 16'h0000) begin errors++; $display("FAIL sat_lo_score got=%h exp=0000", ia.o_score); end
        ack();
    endtask
    task automatic test_backpressure();
        set_w(16'h0080, 16'h0000, 16'h0040, 16'h0000);
        run(fill(16'h0000));
        checks++; if (ia.o_logit !== 16'h0000 || ia.o_score !== 16'h0080) begin errors++; $display("FAIL bp_first got=%h/%h exp=0000/0080", ia.o_logit, ia.o_score); end
        drive(1'b1, fill(16'h0100), 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0 || ia.o_logit !== 16'h0000 || ia.o_score !== 16'h0080) begin
                errors++;
                $display("FAIL bp_hold%0d got=v%b r%b %h/%h exp=v1 r0 0000/0080", c, ia.out_valid, ia.in_ready, ia.o_logit, ia.o_score);
            end
        end
        drive(1'b1, fill(16'h0100), 1'b1);
        step();
        checks++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", ia.out_valid, ia.in_ready); end
        drive(1'b1, fill(16'h0100), 1'b0);
        step();
        drive(1'b0, fill(16'hDEAD), 1'b0);
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", ia.in_ready); end
        wait_done(lat);
        checks++; if (lat != L) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, L); end
        checks++; if (ia.o_logit !== 16'h00C0) begin errors++; $display("FAIL bp_logit got=%h exp=00C0", ia.o_logit); end
        ack();
    endtask
    task automatic test_reset_midop();
        drive(1'b1, fill(16'h0100), 1'b0);
        step();
        drive(1'b0, fill(16'hDEAD), 1'b0);
        repeat (11) step();
        rst_n = 1'b0;
        step();
        checks++; if (ia.out_valid !== 1'b0 || ia.o_logit !== 16'h0000 || ia.o_score !== 16'h0000) begin errors++; $display("FAIL midop_clear got=v%b %h/%h exp=v0 0000/0000", ia.out_valid, ia.o_logit, ia.o_score); end
        checks++; if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL midop_ready_low got=%b exp=0", ia.in_ready); end
        step();
        checks++; if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b0) begin errors++; $display("FAIL midop_held got=r%b v%b exp=r0 v0", ia.in_ready, ia.out_valid); end
        rst_n = 1'b1;
        step();
        checks++; if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL midop_ready_high got=%b exp=1", ia.in_ready); end
        run(fill(16'h0100));
        checks++; if (lat != L) begin errors++; $display("FAIL midop_latency got=%0d exp=%0d", lat, L); end
        checks++; if (ia.o_logit !== 16'h00C0 || ia.o_score !== 16'h00B0) begin errors++; $display("FAIL midop_result got=%h/%h exp=00C0/00B0", ia.o_logit, ia.o_score); end
        ack();
    endtask
    task automatic test_small();
        int n;
        for (int k = 0; k < 10; k++)
            w1s[DW*k +: DW] = (k % 5 == 4) ? 16'h0000 : 16'h0080;
        w2s = {16'h0000, 16'h0040, 16'h0040};
        ic.in_pixels = {4{16'h0100}};
        ic.in_valid = 1'b1;
        step();
        ic.in_valid = 1'b0;
        ic.in_pixels = '1;
        n = 0;
        do begin
            step();
            n++;
        end while (!ic.out_valid && n < 200);
        checks++; if (n != 13) begin errors++; $display("FAIL small_latency got=%0d exp=13", n); end
        checks++; if (ic.o_logit !== 16'h0080) begin errors++; $display("FAIL small_logit got=%h exp=0080", ic.o_logit); end
        checks++; if (ic.o_score !== 16'h00A0) begin errors++; $display("FAIL small_score got=%h exp=00A0", ic.o_score); end
        ic.out_ready = 1'b1;
        step();
        ic.out_ready = 1'b0;
        checks++; if (ic.out_valid !== 1'b0 || ic.in_ready !== 1'b1) begin errors++; $display("FAIL small_ack got=v%b r%b exp=v0 r1", ic.out_valid, ic.in_ready); end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_midop();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
